// File: rtl/arbitro_mux.sv
// Round-robin arbiter that drives the selector of a shared 4:1 mux from four level requests.
// Build with ARBITRO_QUOTA_EN to withdraw a grant after QUOTA cycles while another requester waits.
module arbitro_mux #(
  parameter int QUOTA        = 8,
  parameter int LARGURA_CONT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] requisicao,
  output logic [3:0] concessao,
  output logic [1:0] seletor,
  output logic       ocupado
);

  typedef enum logic [1:0] {LIVRE, CONCEDIDO, GUARDA} estado_t;

  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

  estado_t                 r_estado;
  logic [1:0]              r_ultimo;
  logic [LARGURA_CONT-1:0] r_contador;
  logic [3:0]              r_concessao;
  logic [1:0]              r_seletor;
  logic                    r_ocupado;

  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_liberar;

  assign concessao = r_concessao;
  assign seletor   = r_seletor;
  assign ocupado   = r_ocupado;

  // Scan from ultimo+1 upward; the later (lower-offset) hit overrides, so the previous owner is last.
  always_comb begin
    w_win = r_ultimo;
    w_idx = r_ultimo;
    w_any = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ultimo + 2'(k);
      if (requisicao[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

`ifdef ARBITRO_QUOTA_EN
  logic w_outros;
  assign w_outros  = |(requisicao & ~(4'b0001 << r_ultimo));
  assign w_liberar = !requisicao[r_ultimo] ||
                     ((r_contador == LARGURA_CONT'(QUOTA - 1)) && w_outros);
`else
  logic w_unused;
  assign w_liberar = !requisicao[r_ultimo];
  assign w_unused  = &{1'b0, r_contador, (QUOTA > 0)};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= LIVRE;
      r_ultimo    <= 2'd3;
      r_contador  <= '0;
      r_concessao <= 4'b0000;
      r_seletor   <= 2'b00;
      r_ocupado   <= 1'b0;
    end else begin
      case (r_estado)
        LIVRE, GUARDA: begin
          if (w_any) begin
            r_estado    <= CONCEDIDO;
            r_concessao <= 4'b0001 << w_win;
            r_seletor   <= w_win;
            r_ocupado   <= 1'b1;
            r_ultimo    <= w_win;
            r_contador  <= '0;
          end else begin
            r_estado <= LIVRE;
          end
        end
        CONCEDIDO: begin
          if (r_contador != CONT_MAX) begin
            r_contador <= r_contador + 1'b1;
          end
          // Seletor is left alone so the mux output stays put while idle.
          if (w_liberar) begin
            r_estado    <= GUARDA;
            r_concessao <= 4'b0000;
            r_ocupado   <= 1'b0;
          end
        end
        default: begin
          r_estado    <= LIVRE;
          r_concessao <= 4'b0000;
          r_ocupado   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux.sv
// Self-checking bench for arbitro_mux; expected {concessao,seletor,ocupado} queued per driven cycle.
module tb_arbitro_mux;

  logic       clock;
  logic       reset;
  logic [3:0] requisicao;
  logic [3:0] concessao;
  logic [1:0] seletor;
  logic       ocupado;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] q_exp [$];
  logic [6:0] got_exp;

  arbitro_mux #(.QUOTA(8), .LARGURA_CONT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .requisicao (requisicao),
    .concessao  (concessao),
    .seletor    (seletor),
    .ocupado    (ocupado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    requisicao = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    q_exp.delete();
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({concessao, seletor, ocupado} !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_initial: got %b/%b/%b want 0000/00/0", concessao, seletor, ocupado);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      requisicao = 4'b0100;
      q_exp.push_back({4'b0100, 2'b10, 1'b1});
      @(negedge clock);
      got_exp = q_exp.pop_front();
      n_checks++;
      if ({concessao, seletor, ocupado} !== got_exp) begin
        n_fail++;
        $display("FAIL reset_pregrant cyc %0d: got %b/%b/%b want %b", i, concessao, seletor, ocupado, got_exp);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({concessao, seletor, ocupado} !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_async: got %b/%b/%b want 0000/00/0", concessao, seletor, ocupado);
    end
    @(negedge clock);
    reset = 1'b0;
    requisicao = 4'b1111;
    q_exp.push_back({4'b0001, 2'b00, 1'b1});
    requisicao = 4'b1111;
    @(negedge clock);
    got_exp = q_exp.pop_front();
    n_checks++;
    if ({concessao, seletor, ocupado} !== got_exp) begin
      n_fail++;
      $display("FAIL reset_first_priority: got %b/%b/%b want %b", concessao, seletor, ocupado, got_exp);
    end
    requisicao = 4'b0000;
    q_exp.push_back({4'b0000, 2'b00, 1'b0});
    @(negedge clock);
    got_exp = q_exp.pop_front();
    n_checks++;
    if ({concessao, seletor, ocupado} !== got_exp) begin
      n_fail++;
      $display("FAIL reset_release: got %b/%b/%b want %b", concessao, seletor, ocupado, got_exp);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      requisicao = (i < 5) ? 4'b0100 : 4'b0000;
      q_exp.push_back((i < 5) ? {4'b0100, 2'b10, 1'b1} : {4'b0000, 2'b10, 1'b0});
      @(negedge clock);
      got_exp = q_exp.pop_front();
      n_checks++;
      if ({concessao, seletor, ocupado} !== got_exp) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %b/%b/%b want %b", i, concessao, seletor, ocupado, got_exp);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] oh;
    logic [1:0] own;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      own = 2'(k % 4);
      oh  = 4'b0001 << own;
      for (int p = 0; p < 3; p++) begin
        requisicao = (p == 2) ? (4'b1111 & ~oh) : 4'b1111;
        q_exp.push_back((p == 2) ? {4'b0000, own, 1'b0} : {oh, own, 1'b1});
        @(negedge clock);
        got_exp = q_exp.pop_front();
        n_checks++;
        if ({concessao, seletor, ocupado} !== got_exp) begin
          n_fail++;
          $display("FAIL rotation owner %0d phase %0d: got %b/%b/%b want %b", k, p, concessao, seletor, ocupado, got_exp);
        end
      end
    end
  endtask

  task automatic test_wraparound();
    logic [3:0] reqs [4];
    logic [6:0] exps [4];
    reqs = '{4'b1000, 4'b0000, 4'b1001, 4'b0000};
    exps = '{{4'b1000, 2'b11, 1'b1}, {4'b0000, 2'b11, 1'b0},
             {4'b0001, 2'b00, 1'b1}, {4'b0000, 2'b00, 1'b0}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      requisicao = reqs[i];
      q_exp.push_back(exps[i]);
      @(negedge clock);
      got_exp = q_exp.pop_front();
      n_checks++;
      if ({concessao, seletor, ocupado} !== got_exp) begin
        n_fail++;
        $display("FAIL wraparound cyc %0d: got %b/%b/%b want %b", i, concessao, seletor, ocupado, got_exp);
      end
    end
  endtask

  task automatic test_pulse_ignored();
    logic [3:0] reqs [5];
    logic [6:0] exps [5];
    reqs = '{4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
    exps = '{{4'b0001, 2'b00, 1'b1}, {4'b0001, 2'b00, 1'b1}, {4'b0001, 2'b00, 1'b1},
             {4'b0000, 2'b00, 1'b0}, {4'b0000, 2'b00, 1'b0}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      requisicao = reqs[i];
      q_exp.push_back(exps[i]);
      @(negedge clock);
      got_exp = q_exp.pop_front();
      n_checks++;
      if ({concessao, seletor, ocupado} !== got_exp) begin
        n_fail++;
        $display("FAIL pulse_ignored cyc %0d: got %b/%b/%b want %b", i, concessao, seletor, ocupado, got_exp);
      end
    end
  endtask

  task automatic test_quota();
    int hold;
    do_reset();
`ifdef ARBITRO_QUOTA_EN
    hold = 8;
`else
    hold = 12;
`endif
    for (int i = 0; i < hold; i++) begin
      requisicao = 4'b0110;
      q_exp.push_back({4'b0010, 2'b01, 1'b1});
      @(negedge clock);
      got_exp = q_exp.pop_front();
      n_checks++;
      if ({concessao, seletor, ocupado} !== got_exp) begin
        n_fail++;
        $display("FAIL quota_hold cyc %0d: got %b/%b/%b want %b", i, concessao, seletor, ocupado, got_exp);
      end
    end
`ifdef ARBITRO_QUOTA_EN
    requisicao = 4'b0110;
`else
    requisicao = 4'b0100;
`endif
    q_exp.push_back({4'b0000, 2'b01, 1'b0});
    @(negedge clock);
    got_exp = q_exp.pop_front();
    n_checks++;
    if ({concessao, seletor, ocupado} !== got_exp) begin
      n_fail++;
      $display("FAIL quota_gap: got %b/%b/%b want %b", concessao, seletor, ocupado, got_exp);
    end
    q_exp.push_back({4'b0100, 2'b10, 1'b1});
    @(negedge clock);
    got_exp = q_exp.pop_front();
    n_checks++;
    if ({concessao, seletor, ocupado} !== got_exp) begin
      n_fail++;
      $display("FAIL quota_next_owner: got %b/%b/%b want %b", concessao, seletor, ocupado, got_exp);
    end
    requisicao = 4'b0000;
    q_exp.push_back({4'b0000, 2'b10, 1'b0});
    @(negedge clock);
    got_exp = q_exp.pop_front();
    n_checks++;
    if ({concessao, seletor, ocupado} !== got_exp) begin
      n_fail++;
      $display("FAIL quota_drain: got %b/%b/%b want %b", concessao, seletor, ocupado, got_exp);
    end
  endtask

  task automatic test_no_contender();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      requisicao = 4'b0001;
      q_exp.push_back({4'b0001, 2'b00, 1'b1});
      @(negedge clock);
      got_exp = q_exp.pop_front();
      n_checks++;
      if ({concessao, seletor, ocupado} !== got_exp) begin
        n_fail++;
        $display("FAIL no_contender cyc %0d: got %b/%b/%b want %b", i, concessao, seletor, ocupado, got_exp);
      end
    end
    requisicao = 4'b0000;
    @(negedge clock);
  endtask

  initial begin
    reset      = 1'b1;
    requisicao = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_wraparound();
    test_pulse_ignored();
    test_quota();
    test_no_contender();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
